// File: rtl/uart_rx_frame_parser_if.sv
// Byte-stream and frame-handoff signals between the UART receiver, the frame parser and the host.
// master = upstream receiver plus host side, slave = the parser itself.
interface uart_rx_frame_parser_if #(
    parameter int MAX_LEN = 16
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic          i_rx_dv;
    logic [7:0]    i_rx_byte;
    logic          o_frame_valid;
    logic [7:0]    o_frame_cmd;
    logic [7:0]    o_frame_len;
    logic          i_frame_ack;
    logic [AW-1:0] i_rd_addr;
    logic [7:0]    o_rd_data;
    logic          o_err;
    logic [1:0]    o_err_code;
    logic          o_overrun;

    modport master (
        output i_rx_dv, i_rx_byte, i_frame_ack, i_rd_addr,
        input  o_frame_valid, o_frame_cmd, o_frame_len, o_rd_data,
               o_err, o_err_code, o_overrun
    );

    modport slave (
        input  i_rx_dv, i_rx_byte, i_frame_ack, i_rd_addr,
        output o_frame_valid, o_frame_cmd, o_frame_len, o_rd_data,
               o_err, o_err_code, o_overrun
    );
endinterface

// File: rtl/uart_rx_frame_parser.sv
// Assembles SYNC/CMD/LEN/payload/XOR-checksum frames from UART bytes and holds one good frame for the host.
// Status and error pulses are registered one cycle after the byte; read port has one cycle latency.
// Bytes arriving while a frame is held are dropped and flagged as overrun; host releases with ack.
module uart_rx_frame_parser #(
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 8680,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_rx_frame_parser_if.slave bus
);
    localparam int             AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int             TW       = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]     MAX_LEN8 = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT,
        S_CMD,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_HOLD
    } state_t;

    state_t        state, state_d;
    logic [7:0]    acc, acc_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    idx, idx_d;
    logic [TW-1:0] tmo_cnt, tmo_d;
    logic          frame_valid, valid_d;
    logic [7:0]    frame_cmd, fcmd_d;
    logic [7:0]    frame_len, flen_d;
    logic          err, err_d;
    logic [1:0]    err_code, code_d;
    logic          overrun, ovr_d;
    logic          buf_we;
    logic          in_frame;
    logic          tmo_hit;
    logic [7:0]    rd_data;
    logic [7:0]    mem [0:MAX_LEN-1];

    assign in_frame = (state == S_CMD) || (state == S_LEN) ||
                      (state == S_PAYLOAD) || (state == S_CSUM);
    // A byte landing on the last count cycle wins over the timeout.
    assign tmo_hit  = in_frame && !bus.i_rx_dv && (tmo_cnt == TMO_LAST);

    always_comb begin
        state_d = state;
        acc_d   = acc;
        cmd_d   = cmd_q;
        len_d   = len_q;
        idx_d   = idx;
        valid_d = frame_valid;
        fcmd_d  = frame_cmd;
        flen_d  = frame_len;
        err_d   = 1'b0;
        code_d  = 2'b00;
        ovr_d   = 1'b0;
        buf_we  = 1'b0;
        tmo_d   = (in_frame && !bus.i_rx_dv) ? tmo_cnt + 1'b1 : '0;

        case (state)
            S_HUNT: begin
                if (bus.i_rx_dv && bus.i_rx_byte == SYNC_BYTE)
                    state_d = S_CMD;
            end
            S_CMD: begin
                if (bus.i_rx_dv) begin
                    cmd_d   = bus.i_rx_byte;
                    acc_d   = bus.i_rx_byte;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (bus.i_rx_dv) begin
                    if (bus.i_rx_byte > MAX_LEN8) begin
                        err_d   = 1'b1;
                        code_d  = 2'b01;
                        state_d = S_HUNT;
                    end else begin
                        len_d   = bus.i_rx_byte;
                        acc_d   = acc ^ bus.i_rx_byte;
                        idx_d   = 8'd0;
                        state_d = (bus.i_rx_byte == 8'd0) ? S_CSUM : S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (bus.i_rx_dv) begin
                    buf_we = 1'b1;
                    acc_d  = acc ^ bus.i_rx_byte;
                    if (idx == len_q - 8'd1)
                        state_d = S_CSUM;
                    else
                        idx_d = idx + 8'd1;
                end
            end
            S_CSUM: begin
                if (bus.i_rx_dv) begin
                    if (bus.i_rx_byte == acc) begin
                        valid_d = 1'b1;
                        fcmd_d  = cmd_q;
                        flen_d  = len_q;
                        state_d = S_HOLD;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = 2'b10;
                        state_d = S_HUNT;
                    end
                end
            end
            S_HOLD: begin
                if (bus.i_rx_dv)
                    ovr_d = 1'b1;
                if (bus.i_frame_ack) begin
                    valid_d = 1'b0;
                    state_d = S_HUNT;
                end
            end
            default: state_d = S_HUNT;
        endcase

        if (tmo_hit) begin
            err_d   = 1'b1;
            code_d  = 2'b11;
            state_d = S_HUNT;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_HUNT;
            acc         <= 8'd0;
            cmd_q       <= 8'd0;
            len_q       <= 8'd0;
            idx         <= 8'd0;
            tmo_cnt     <= '0;
            frame_valid <= 1'b0;
            frame_cmd   <= 8'd0;
            frame_len   <= 8'd0;
            err         <= 1'b0;
            err_code    <= 2'b00;
            overrun     <= 1'b0;
        end else begin
            state       <= state_d;
            acc         <= acc_d;
            cmd_q       <= cmd_d;
            len_q       <= len_d;
            idx         <= idx_d;
            tmo_cnt     <= tmo_d;
            frame_valid <= valid_d;
            frame_cmd   <= fcmd_d;
            frame_len   <= flen_d;
            err         <= err_d;
            err_code    <= code_d;
            overrun     <= ovr_d;
        end
    end

    // Payload storage carries no reset; contents only matter while a frame is held.
    always_ff @(posedge clk) begin
        if (buf_we)
            mem[idx[AW-1:0]] <= bus.i_rx_byte;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= 8'd0;
        else if (32'(bus.i_rd_addr) < MAX_LEN)
            rd_data <= mem[bus.i_rd_addr];
        else
            rd_data <= 8'd0;
    end

    assign bus.o_frame_valid = frame_valid;
    assign bus.o_frame_cmd   = frame_cmd;
    assign bus.o_frame_len   = frame_len;
    assign bus.o_rd_data     = rd_data;
    assign bus.o_err         = err;
    assign bus.o_err_code    = err_code;
    assign bus.o_overrun     = overrun;
endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Bench for uart_rx_frame_parser: vector table of frames plus hand sequences for timeout, overrun, reset.
// Expected frame/error/overrun events are queued as bytes are driven and matched as the DUT reports them.
module tb_uart_rx_frame_parser;
    localparam int MAX_LEN = 12;
    localparam int TMO     = 20;
    localparam int AW      = $clog2(MAX_LEN);

    localparam int K_FRAME = 0;
    localparam int K_ERR   = 1;
    localparam int K_OVR   = 2;

    typedef struct {
        int               kind;
        logic [1:0]       code;
        logic [7:0]       cmd;
        logic [7:0]       len;
    } ev_t;

    typedef struct {
        int               n;
        logic [0:7][7:0]  b;
        int               kind;
        logic [1:0]       code;
        logic [7:0]       cmd;
        logic [7:0]       len;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic prev_valid = 1'b0;
    ev_t  exp_q [$];
    vec_t vecs [7];

    uart_rx_frame_parser_if #(.MAX_LEN(MAX_LEN)) bus ();

    uart_rx_frame_parser #(
        .MAX_LEN      (MAX_LEN),
        .TIMEOUT_CLKS (TMO),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [1:0] code, input logic [7:0] cmd, input logic [7:0] len);
        ev_t e;
        e.kind = kind; e.code = code; e.cmd = cmd; e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", 32'(kind), 32'hFF);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            if (kind == K_FRAME && e.kind == K_FRAME) begin
                chk("frame_cmd", 32'(bus.o_frame_cmd), 32'(e.cmd));
                chk("frame_len", 32'(bus.o_frame_len), 32'(e.len));
            end
            if (kind == K_ERR && e.kind == K_ERR)
                chk("err_code", 32'(bus.o_err_code), 32'(e.code));
        end
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst) begin
            if (bus.o_frame_valid && !prev_valid) pop_check(K_FRAME);
            if (bus.o_err) pop_check(K_ERR);
            else if (bus.o_err_code != 2'b00) chk("code_idle", 32'(bus.o_err_code), 0);
            if (bus.o_overrun) pop_check(K_OVR);
        end
        prev_valid = bus.o_frame_valid;
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_rx_dv   = 1'b1;
        bus.i_rx_byte = b;
        tick();
        bus.i_rx_dv   = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (3) tick();
        chk(name, 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic rd(input int a, input logic [7:0] want);
        bus.i_rd_addr = AW'(a);
        tick();
        chk("rd_data", 32'(bus.o_rd_data), 32'(want));
    endtask

    task automatic ack();
        bus.i_frame_ack = 1'b1;
        tick();
        bus.i_frame_ack = 1'b0;
        chk("valid_after_ack", 32'(bus.o_frame_valid), 0);
    endtask

    initial begin
        logic [7:0] pl [MAX_LEN];
        logic [7:0] cs;

        vecs[0] = '{n:7, b:{8'hA5,8'h10,8'h03,8'h01,8'h02,8'h03,8'h13,8'h00}, kind:K_FRAME, code:2'b00, cmd:8'h10, len:8'h03};
        vecs[1] = '{n:6, b:{8'h00,8'hFF,8'hA5,8'h20,8'h00,8'h20,8'h00,8'h00}, kind:K_FRAME, code:2'b00, cmd:8'h20, len:8'h00};
        vecs[2] = '{n:7, b:{8'hA5,8'h10,8'h03,8'h01,8'h02,8'h03,8'h14,8'h00}, kind:K_ERR,   code:2'b10, cmd:8'h00, len:8'h00};
        vecs[3] = '{n:3, b:{8'hA5,8'h10,8'h11,8'h00,8'h00,8'h00,8'h00,8'h00}, kind:K_ERR,   code:2'b01, cmd:8'h00, len:8'h00};
        vecs[4] = '{n:3, b:{8'hA5,8'h10,8'h0D,8'h00,8'h00,8'h00,8'h00,8'h00}, kind:K_ERR,   code:2'b01, cmd:8'h00, len:8'h00};
        vecs[5] = '{n:5, b:{8'hA5,8'hA5,8'h01,8'hA5,8'h01,8'h00,8'h00,8'h00}, kind:K_FRAME, code:2'b00, cmd:8'hA5, len:8'h01};
        vecs[6] = '{n:6, b:{8'hA5,8'h30,8'h02,8'hAA,8'h55,8'hCD,8'h00,8'h00}, kind:K_FRAME, code:2'b00, cmd:8'h30, len:8'h02};

        bus.i_rx_dv     = 1'b0;
        bus.i_rx_byte   = 8'h00;
        bus.i_frame_ack = 1'b0;
        bus.i_rd_addr   = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_valid",   32'(bus.o_frame_valid), 0);
        chk("rst_cmd",     32'(bus.o_frame_cmd), 0);
        chk("rst_len",     32'(bus.o_frame_len), 0);
        chk("rst_rd_data", 32'(bus.o_rd_data), 0);
        chk("rst_err",     32'(bus.o_err), 0);
        chk("rst_code",    32'(bus.o_err_code), 0);
        chk("rst_ovr",     32'(bus.o_overrun), 0);

        // Ack outside HOLD must be ignored.
        bus.i_frame_ack = 1'b1;
        tick();
        bus.i_frame_ack = 1'b0;

        for (int v = 0; v < 7; v++) begin
            expect_ev(vecs[v].kind, vecs[v].code, vecs[v].cmd, vecs[v].len);
            for (int i = 0; i < vecs[v].n; i++) send(vecs[v].b[i]);
            if (vecs[v].kind == K_ERR)
                chk("err_latency", 32'(bus.o_err), 1);
            if (vecs[v].kind == K_FRAME) begin
                chk("vec_valid", 32'(bus.o_frame_valid), 1);
                for (int i = 0; i < int'(vecs[v].len); i++)
                    rd(i, vecs[v].b[vecs[v].n - 1 - int'(vecs[v].len) + i]);
                rd(MAX_LEN, 8'h00);
                ack();
            end else begin
                chk("vec_no_valid", 32'(bus.o_frame_valid), 0);
            end
            drain("vec_drain");
        end

        // Length exactly MAX_LEN, checksum computed by the bench.
        cs = 8'h42 ^ 8'(MAX_LEN);
        for (int i = 0; i < MAX_LEN; i++) begin
            pl[i] = 8'(i * 7 + 1);
            cs    = cs ^ pl[i];
        end
        expect_ev(K_FRAME, 2'b00, 8'h42, 8'(MAX_LEN));
        send(8'hA5); send(8'h42); send(8'(MAX_LEN));
        for (int i = 0; i < MAX_LEN; i++) send(pl[i]);
        send(cs);
        for (int i = 0; i < MAX_LEN; i++) rd(i, pl[i]);
        rd(MAX_LEN + 3, 8'h00);
        ack();
        drain("maxlen_drain");

        // Silence after CMD: error on exactly the TMO-th idle edge.
        expect_ev(K_ERR, 2'b11, 8'h00, 8'h00);
        send(8'hA5); send(8'h10);
        repeat (TMO - 1) tick();
        chk("tmo_not_yet", 32'(bus.o_err), 0);
        tick();
        chk("tmo_fire", 32'(bus.o_err), 1);
        chk("tmo_code", 32'(bus.o_err_code), 2'b11);
        repeat (TMO + 5) tick();
        drain("tmo_drain");

        // Byte on the final count cycle is accepted.
        expect_ev(K_FRAME, 2'b00, 8'h10, 8'h01);
        send(8'hA5); send(8'h10);
        repeat (TMO - 1) tick();
        send(8'h01);
        send(8'hAB);
        send(8'h10 ^ 8'h01 ^ 8'hAB);
        chk("edge_valid", 32'(bus.o_frame_valid), 1);
        rd(0, 8'hAB);
        ack();
        drain("edge_drain");

        // Overrun while held, then overrun on the ack cycle.
        expect_ev(K_FRAME, 2'b00, 8'h10, 8'h03);
        for (int i = 0; i < 7; i++) send(vecs[0].b[i]);
        expect_ev(K_OVR, 2'b00, 8'h00, 8'h00);
        send(8'h55);
        chk("ovr_pulse", 32'(bus.o_overrun), 1);
        chk("ovr_valid", 32'(bus.o_frame_valid), 1);
        chk("ovr_cmd",   32'(bus.o_frame_cmd), 8'h10);
        chk("ovr_len",   32'(bus.o_frame_len), 8'h03);
        rd(0, 8'h01); rd(1, 8'h02); rd(2, 8'h03);
        expect_ev(K_OVR, 2'b00, 8'h00, 8'h00);
        bus.i_rx_dv = 1'b1; bus.i_rx_byte = 8'h66; bus.i_frame_ack = 1'b1;
        tick();
        bus.i_rx_dv = 1'b0; bus.i_frame_ack = 1'b0;
        chk("ack_ovr_pulse", 32'(bus.o_overrun), 1);
        chk("ack_ovr_valid", 32'(bus.o_frame_valid), 0);
        drain("ovr_drain");

        // Reset mid-payload: no error, all outputs cleared, next frame parses.
        send(8'hA5); send(8'h10); send(8'h03); send(8'h01);
        bus.i_rd_addr = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(bus.o_frame_valid), 0);
        chk("mid_rst_cmd",   32'(bus.o_frame_cmd), 0);
        chk("mid_rst_len",   32'(bus.o_frame_len), 0);
        chk("mid_rst_rd",    32'(bus.o_rd_data), 0);
        chk("mid_rst_err",   32'(bus.o_err), 0);
        chk("mid_rst_ovr",   32'(bus.o_overrun), 0);
        drain("mid_rst_quiet");
        expect_ev(K_FRAME, 2'b00, 8'h30, 8'h02);
        for (int i = 0; i < 6; i++) send(vecs[6].b[i]);
        rd(0, 8'hAA); rd(1, 8'h55);
        ack();
        drain("post_rst_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame_parser.md
Name: uart_rx_frame_parser

Overview:
- Sits directly downstream of the UART receiver. Consumes its one-cycle data-valid strobe and received byte.
- Assembles framed command packets: sync, command, length, payload and XOR checksum.
- Buffers the payload and presents each complete, checksum-correct frame to the host logic through a valid/ack handshake and a registered read port.
- Rejects malformed, oversized and stalled frames with an error pulse and code.

Parameters:
- MAX_LEN, 16, maximum payload bytes per frame and buffer depth (1..255).
- TIMEOUT_CLKS, 8680, idle clocks allowed between bytes inside a frame (about 4 byte times at 217 clks/bit).
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- i_rx_dv  in  1  byte-valid strobe from the UART receiver, one cycle per byte
- i_rx_byte  in  8  received byte, qualified by i_rx_dv
- o_frame_valid  out  1  complete good frame held in the buffer
- o_frame_cmd  out  8  command byte of the held frame
- o_frame_len  out  8  payload length of the held frame
- i_frame_ack  in  1  consumer releases the held frame
- i_rd_addr  in  $clog2(MAX_LEN)  payload read address
- o_rd_data  out  8  payload byte at i_rd_addr, registered
- o_err  out  1  one-cycle pulse: frame rejected
- o_err_code  out  2  reason, valid with o_err: 01 length > MAX_LEN, 10 checksum mismatch, 11 inter-byte timeout
- o_overrun  out  1  one-cycle pulse: byte dropped because a frame was held

Behaviour:
- Reset: all outputs 0, state HUNT, checksum and counters 0. Buffer contents are don't-care.
- Reset mid-frame discards the partial frame and emits no error pulse.
- Frame format: SYNC, CMD, LEN, LEN payload bytes, CSUM.
  - CSUM = XOR of CMD, LEN and all payload bytes; SYNC is excluded.
- Bytes are processed only in cycles where i_rx_dv=1.
- HUNT:
  - On a byte equal to SYNC_BYTE, go to CMD.
  - Any other byte is silently discarded.
- CMD: latch the byte into the command register, set the accumulator to the byte, go to LEN.
- LEN:
  - If the byte > MAX_LEN: pulse o_err with code 01 and go to HUNT.
  - Otherwise latch the length, XOR it into the accumulator, clear the byte index.
  - Go to PAYLOAD if LEN>0, or directly to CSUM if LEN=0.
- PAYLOAD:
  - Write the byte to buffer[index] and XOR it into the accumulator.
  - When index = LEN-1, go to CSUM; otherwise increment the index.
- CSUM:
  - If the byte equals the accumulator: set o_frame_valid=1 on the next cycle, update o_frame_cmd and o_frame_len, go to HOLD.
  - Otherwise pulse o_err with code 10 and go to HUNT.
  - A SYNC_BYTE arriving in CMD/LEN/PAYLOAD/CSUM is treated as data, with no resync.
- HOLD:
  - o_frame_valid, o_frame_cmd and o_frame_len stay stable; the buffer is not written.
  - i_frame_ack=1 clears o_frame_valid on the next cycle and returns to HUNT.
  - Any i_rx_dv while in HOLD, including the ack cycle, drops the byte and pulses o_overrun.
  - i_frame_ack outside HOLD is ignored.
- Timeout:
  - Counter clears on every i_rx_dv and increments each cycle while in CMD/LEN/PAYLOAD/CSUM.
  - When it reaches TIMEOUT_CLKS-1 with no i_rx_dv that cycle, pulse o_err with code 11 and go to HUNT.
  - If i_rx_dv coincides with that cycle, the byte is processed and no timeout fires.
  - The counter is held at 0 in HUNT and HOLD.
- Error/status pulses: o_err, o_err_code and o_overrun are registered and assert the cycle after the offending byte or timeout edge. o_err_code reads 00 when o_err=0.
- Read port:
  - o_rd_data = buffer[i_rd_addr] one cycle after the address is presented; usable in any state.
  - Contents are guaranteed only while o_frame_valid=1.
  - Addresses ≥ MAX_LEN return 8'h00.
- Widths: the index and length compare are 8-bit. The buffer index never exceeds MAX_LEN-1.

Test Plan:
- Bytes A5 10 03 01 02 03 13 -> o_frame_valid=1, cmd=0x10, len=3; reading addresses 0..2 returns 01 02 03 one cycle after each address; ack -> valid=0 next cycle.
- Bytes 00 FF A5 20 00 20 -> leading garbage ignored; valid frame with cmd=0x20, len=0 and no payload writes.
- Bytes A5 10 03 01 02 03 14 -> o_err pulse with code 10, no frame_valid; a following good frame is accepted.
- Bytes A5 10 11 -> o_err code 01 right after the LEN byte; the next A5 starts a new frame.
- A5 10, then silence for TIMEOUT_CLKS cycles -> o_err code 11 exactly once. A byte arriving on the final count cycle is accepted with no error.
- Good frame held, then byte 0x55 arrives with no ack -> o_overrun pulse; held cmd, len and payload unchanged. Reset asserted mid-PAYLOAD -> all outputs 0, and the next good frame parses correctly.
